// File: rtl/spi_pkg.sv
// Shared definitions for the SPI configuration initiator: FSM states,
// word size, clock mode and the divider limits.
package spi_pkg;

  localparam int SPI_WORD_BITS   = 32;
  localparam int SPI_BITCNT_W    = 6;
  localparam bit SPI_CPOL        = 1'b0;
  localparam bit SPI_CPHA        = 1'b0;
  localparam int SPI_CLK_DIV_MIN = 2;
  localparam int SPI_CLK_DIV_MAX = 255;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_config_controller_if.sv
// Host handshake plus SPI pin bundle for the configuration initiator.
// master = the initiator itself, slave = whatever drives start/tx_data/miso.
interface spi_config_controller_if #(
  parameter int WORD_BITS = spi_pkg::SPI_WORD_BITS
);

  logic                 start;
  logic [WORD_BITS-1:0] tx_data;
  logic                 busy;
  logic                 done;
  logic [WORD_BITS-1:0] rx_data;
  logic                 ss;
  logic                 sclk;
  logic                 mosi;
  logic                 miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, ss, sclk, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, ss, sclk, mosi
  );

endinterface

// File: rtl/spi_tick_gen.sv
// Reloadable down-counter: tick is high for the one cycle in which the
// count reaches zero, i.e. CLK_DIV cycles after the last load.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int               CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RELOAD;
    end else if (load) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign tick = (r_count == '0);

endmodule

// File: rtl/spi_config_controller.sv
// Mode-0 SPI initiator: shifts one word out MSB-first on mosi while
// shifting the peripheral's reply in from miso, then holds ss high for a gap.
module spi_config_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = SPI_WORD_BITS
) (
  input logic                     clk,
  input logic                     rst,
  spi_config_controller_if.master bus
);

  localparam logic [SPI_BITCNT_W-1:0] LAST_BIT = SPI_BITCNT_W'(WORD_BITS - 1);

  spi_state_t r_state;
  spi_state_t w_nextState;

  logic [WORD_BITS-1:0]    r_txShift;
  logic [WORD_BITS-1:0]    r_rxShift;
  logic [WORD_BITS-1:0]    r_rxData;
  logic [SPI_BITCNT_W-1:0] r_bitCnt;
  logic                    r_done;

  logic w_tick;
  logic w_load;
  logic w_accept;
  logic w_lastBit;
  logic w_ss;
  logic w_sclk;
  logic w_mosi;
  logic w_busy;

  // Every non-idle state leaves on a tick, so reloading on tick doubles as
  // reloading on state entry; parking in IDLE keeps the first period full.
  assign w_load    = w_tick || (r_state == IDLE);
  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_lastBit = (r_bitCnt == LAST_BIT);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tickGen (
    .clk (clk),
    .rst (rst),
    .load(w_load),
    .tick(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_ss        = 1'b1;
    w_sclk      = SPI_CPOL;
    w_mosi      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_nextState = SETUP;
      end
      SETUP: begin
        w_ss   = 1'b0;
        w_mosi = r_txShift[WORD_BITS-1];
        if (w_tick) w_nextState = HIGH;
      end
      HIGH: begin
        w_ss   = 1'b0;
        w_sclk = ~SPI_CPOL;
        w_mosi = r_txShift[WORD_BITS-1];
        if (w_tick) w_nextState = w_lastBit ? HOLD : LOW;
      end
      LOW: begin
        w_ss   = 1'b0;
        w_mosi = r_txShift[WORD_BITS-1];
        if (w_tick) w_nextState = HIGH;
      end
      HOLD: begin
        w_ss = 1'b0;
        if (w_tick) w_nextState = GAP;
      end
      GAP: begin
        if (w_tick) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_busy      = 1'b0;
      end
    endcase
  end

  // miso is captured on the falling sclk edge; the tx shift on that same
  // edge is what moves mosi to the next bit while sclk goes low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txShift <= '0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_bitCnt  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_txShift <= bus.tx_data;
        r_bitCnt  <= '0;
      end else if ((r_state == HIGH) && w_tick) begin
        r_rxShift <= {r_rxShift[WORD_BITS-2:0], bus.miso};
        r_txShift <= {r_txShift[WORD_BITS-2:0], 1'b0};
        r_bitCnt  <= r_bitCnt + SPI_BITCNT_W'(1);
      end else if ((r_state == HOLD) && w_tick) begin
        r_rxData <= r_rxShift;
        r_done   <= 1'b1;
      end
    end
  end

  assign bus.ss      = w_ss;
  assign bus.sclk    = w_sclk;
  assign bus.mosi    = w_mosi;
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rxData;

endmodule

// File: tb/tb_spi_config_controller.sv
// Scoreboard bench for spi_config_controller: three instances at CLK_DIV 4, 2
// and 255, a small peripheral model on the first, loopbacks on the others.
module tb_spi_config_controller;

  localparam int DIV_A      = 4;
  localparam int DIV_B      = 2;
  localparam int DIV_C      = 255;
  localparam int DONE_OFF_A = 260;
  localparam int DONE_OFF_B = 130;
  localparam int DONE_OFF_C = 16575;
  localparam int PERIOD_A   = 265;
  localparam int SS_GAP_B   = 3;
  localparam int GUARD      = 20000;

  typedef struct {
    logic [31:0] rx;
    logic [31:0] cfg;
    int          doneCyc;
  } expA_t;

  typedef struct {
    logic [31:0] rx;
    int          doneCyc;
  } expRx_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstBC;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  expA_t  expA[$];
  expRx_t expB[$];
  expRx_t expC[$];

  spi_config_controller_if busA ();
  spi_config_controller_if busB ();
  spi_config_controller_if busC ();

  spi_config_controller #(.CLK_DIV(DIV_A)) dutA (.clk(clk), .rst(rstA),  .bus(busA));
  spi_config_controller #(.CLK_DIV(DIV_B)) dutB (.clk(clk), .rst(rstBC), .bus(busB));
  spi_config_controller #(.CLK_DIV(DIV_C)) dutC (.clk(clk), .rst(rstBC), .bus(busC));

  always #5 clk = ~clk;

  // Cycle index: after edge En, cyc reads n at the following negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Peripheral model for instance A: samples mosi on sclk rise, moves its
  // reply bit on sclk fall, and commits the config word only on a full word.
  logic [31:0] perReply    = 32'hA5A55A5A;
  logic [31:0] perShiftIn  = '0;
  logic [31:0] perCfg      = '0;
  int          perRises    = 0;
  int          perFalls    = 0;
  logic        perPrevSclk = 1'b0;
  logic        perPrevSs   = 1'b1;

  always @(posedge clk) begin
    perPrevSclk <= busA.sclk;
    perPrevSs   <= busA.ss;
    if (busA.ss) begin
      perRises <= 0;
      perFalls <= 0;
      if (!perPrevSs && perRises == 32) perCfg <= perShiftIn;
    end else begin
      if (busA.sclk && !perPrevSclk) begin
        perShiftIn <= {perShiftIn[30:0], busA.mosi};
        perRises   <= perRises + 1;
      end
      if (!busA.sclk && perPrevSclk) perFalls <= perFalls + 1;
    end
  end

  assign busA.miso = (!busA.ss && perFalls < 32) ? perReply[31 - perFalls] : 1'b0;
  assign busB.miso = busB.mosi;
  assign busC.miso = ~busC.mosi;

  // Monitor A: pop on done, check reply word, done timing, ss, then the
  // peripheral's committed config word one cycle later.
  expA_t eA;
  always @(negedge clk) begin
    if (!rstA && busA.done) begin
      if (expA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A_spurious_done: got done=1, expected no transaction (cycle %0d)", cyc);
      end else begin
        eA = expA.pop_front();
        checkOutput("A_rx_data", busA.rx_data, eA.rx);
        checkOutput("A_done_cycle", 32'(cyc), 32'(eA.doneCyc));
        checkOutput("A_ss_high_at_done", {31'd0, busA.ss}, 32'd1);
        @(negedge clk);
        checkOutput("A_peripheral_cfg", perCfg, eA.cfg);
      end
    end
  end

  // Monitor B: loopback words and the ss-high gap between back-to-back words.
  expRx_t eB;
  int     ssHighRunB = 0;
  bit     seenLowB   = 1'b0;
  always @(negedge clk) begin
    if (!rstBC) begin
      if (busB.done) begin
        if (expB.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL B_spurious_done: got done=1, expected no transaction (cycle %0d)", cyc);
        end else begin
          eB = expB.pop_front();
          checkOutput("B_rx_data", busB.rx_data, eB.rx);
          checkOutput("B_done_cycle", 32'(cyc), 32'(eB.doneCyc));
        end
      end
      if (busB.ss) begin
        ssHighRunB++;
      end else begin
        if (seenLowB && ssHighRunB > 0) checkOutput("B_ss_gap", 32'(ssHighRunB), 32'(SS_GAP_B));
        seenLowB   = 1'b1;
        ssHighRunB = 0;
      end
    end
  end

  // Monitor C: every sclk high/low phase is one full divider period and each
  // word carries exactly 32 rising edges.
  expRx_t eC;
  int     runC      = 0;
  int     risesC    = 0;
  logic   prevSclkC = 1'b0;
  logic   prevSsC   = 1'b1;
  always @(negedge clk) begin
    if (!rstBC) begin
      if (busC.done) begin
        if (expC.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL C_spurious_done: got done=1, expected no transaction (cycle %0d)", cyc);
        end else begin
          eC = expC.pop_front();
          checkOutput("C_rx_data", busC.rx_data, eC.rx);
          checkOutput("C_done_cycle", 32'(cyc), 32'(eC.doneCyc));
        end
      end
      if (prevSsC && !busC.ss) begin
        runC   = 1;
        risesC = 0;
      end else if (busC.sclk != prevSclkC) begin
        if (!busC.sclk) begin
          checkOutput("C_sclk_high_period", 32'(runC), 32'(DIV_C));
        end else begin
          risesC++;
          checkOutput("C_sclk_low_period", 32'(runC), 32'(DIV_C));
        end
        runC = 1;
      end else begin
        runC++;
      end
      if (!prevSsC && busC.ss) checkOutput("C_sclk_rises", 32'(risesC), 32'd32);
      prevSclkC = busC.sclk;
      prevSsC   = busC.ss;
    end
  end

  // Issue one word on A from a negedge; the reply is always the model's word.
  task automatic applyStimulus(input logic [31:0] word, input bit expectDone);
    int g = 0;
    while (busA.busy && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (busA.busy) checkOutput("A_wait_idle_timeout", {31'd0, busA.busy}, 32'd0);
    busA.tx_data = word;
    busA.start   = 1'b1;
    if (expectDone) expA.push_back('{rx: 32'hA5A55A5A, cfg: word, doneCyc: cyc + 1 + DONE_OFF_A});
    @(negedge clk);
    busA.start = 1'b0;
  endtask

  task automatic drainWait(input int which);
    int g = 0;
    int left;
    left = (which == 0) ? expA.size() : (which == 1) ? expB.size() : expC.size();
    while (left != 0 && g < GUARD) begin
      @(negedge clk);
      g++;
      left = (which == 0) ? expA.size() : (which == 1) ? expB.size() : expC.size();
    end
    checkOutput($sformatf("queue%0d_drained", which), 32'(left), 32'd0);
  endtask

  task automatic seqA();
    int acc[3];
    applyStimulus(32'h80FC0000, 1'b1);
    drainWait(0);
    // Abort a word 100 cycles in; reply register must clear with reset.
    applyStimulus(32'h12345678, 1'b0);
    repeat (99) @(negedge clk);
    #1 rstA = 1'b1;
    #1;
    checkOutput("A_midreset_ss",   {31'd0, busA.ss},   32'd1);
    checkOutput("A_midreset_sclk", {31'd0, busA.sclk}, 32'd0);
    checkOutput("A_midreset_mosi", {31'd0, busA.mosi}, 32'd0);
    checkOutput("A_midreset_busy", {31'd0, busA.busy}, 32'd0);
    checkOutput("A_midreset_rx",   busA.rx_data,       32'd0);
    @(negedge clk);
    rstA = 1'b0;
    @(negedge clk);
    applyStimulus(32'h12345678, 1'b1);
    drainWait(0);
    // start held high: one acceptance per 265 cycles.
    busA.tx_data = 32'h40000003;
    busA.start   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int g = 0;
      while (busA.busy && g < GUARD) begin
        @(negedge clk);
        g++;
      end
      acc[k] = cyc + 1;
      expA.push_back('{rx: 32'hA5A55A5A, cfg: 32'h40000003, doneCyc: acc[k] + DONE_OFF_A});
      @(negedge clk);
    end
    busA.start = 1'b0;
    checkOutput("A_start_held_period0", 32'(acc[1] - acc[0]), 32'(PERIOD_A));
    checkOutput("A_start_held_period1", 32'(acc[2] - acc[1]), 32'(PERIOD_A));
    drainWait(0);
  endtask

  task automatic seqB();
    int g = 0;
    busB.tx_data = 32'hFFFFFFFF;
    busB.start   = 1'b1;
    expB.push_back('{rx: 32'hFFFFFFFF, doneCyc: cyc + 1 + DONE_OFF_B});
    @(negedge clk);
    busB.tx_data = 32'h00000001;
    while (busB.busy && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    expB.push_back('{rx: 32'h00000001, doneCyc: cyc + 1 + DONE_OFF_B});
    @(negedge clk);
    busB.start = 1'b0;
    drainWait(1);
  endtask

  task automatic seqC();
    busC.tx_data = 32'hA5000000;
    busC.start   = 1'b1;
    expC.push_back('{rx: 32'h5AFFFFFF, doneCyc: cyc + 1 + DONE_OFF_C});
    @(negedge clk);
    busC.start = 1'b0;
    drainWait(2);
  endtask

  initial begin
    busA.start = 1'b0; busA.tx_data = '0;
    busB.start = 1'b0; busB.tx_data = '0;
    busC.start = 1'b0; busC.tx_data = '0;
    rstA  = 1'b1;
    rstBC = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("A_reset_ss",   {31'd0, busA.ss},   32'd1);
    checkOutput("A_reset_sclk", {31'd0, busA.sclk}, 32'd0);
    checkOutput("A_reset_mosi", {31'd0, busA.mosi}, 32'd0);
    checkOutput("A_reset_busy", {31'd0, busA.busy}, 32'd0);
    checkOutput("A_reset_done", {31'd0, busA.done}, 32'd0);
    checkOutput("A_reset_rx",   busA.rx_data,       32'd0);
    checkOutput("B_reset_ss",   {31'd0, busB.ss},   32'd1);
    checkOutput("C_reset_busy", {31'd0, busC.busy}, 32'd0);
    rstA  = 1'b0;
    rstBC = 1'b0;
    @(negedge clk);
    fork
      seqA();
      seqB();
      seqC();
    join
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
